// File: rtl/datain_buf.sv
// Ejection-side packet capture buffer: stores one DEPTH-flit packet into a register file
// with a registered read port. Define DATAIN_BUF_CHECKSUM_EN to build the running XOR checksum.
module datain_buf #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 30,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              enable,
  input  logic              clear,
  input  logic [DATA_W-1:0] datain,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   recv_cnt,
  output logic              op_finish,
  output logic              drop_err,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [ADDR_W:0]   cnt_t;

  state_t            state_q;
  addr_t             wr_addr_q;
  cnt_t              recv_cnt_q;
  logic              op_finish_q;
  logic              drop_err_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic accept, drop, last;

  // clear takes priority: a beat arriving with clear is neither stored nor flagged
  assign accept = in_valid & enable & (state_q != DONE) & ~clear;
  assign drop   = in_valid & ~clear & (~enable | (state_q == DONE));
  assign last   = (wr_addr_q == addr_t'(DEPTH-1));

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      wr_addr_q   <= '0;
      recv_cnt_q  <= '0;
      op_finish_q <= 1'b0;
      drop_err_q  <= 1'b0;
    end else if (clear) begin
      state_q     <= IDLE;
      wr_addr_q   <= '0;
      recv_cnt_q  <= '0;
      op_finish_q <= 1'b0;
      drop_err_q  <= 1'b0;
    end else begin
      if (drop) drop_err_q <= 1'b1;
      case (state_q)
        IDLE: if (accept) begin
          wr_addr_q  <= addr_t'(1);
          recv_cnt_q <= cnt_t'(1);
          state_q    <= RECV;
        end
        RECV: if (accept) begin
          recv_cnt_q <= recv_cnt_q + cnt_t'(1);
          if (last) begin
            wr_addr_q   <= '0;
            op_finish_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            wr_addr_q <= wr_addr_q + addr_t'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately left unreset so it maps onto plain register-file cells
  always_ff @(posedge clk) begin
    if (accept) mem[wr_addr_q] <= datain;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST)                          rd_data_q <= '0;
    else if (rd_addr < addr_t'(DEPTH)) rd_data_q <= mem[rd_addr];
    else                               rd_data_q <= '0;
  end

`ifdef DATAIN_BUF_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST)        checksum_q <= '0;
    else if (clear)  checksum_q <= '0;
    else if (accept) checksum_q <= checksum_q ^ datain;
  end

  assign checksum = checksum_q;
`else
  assign checksum = '0;
`endif

  assign rd_data   = rd_data_q;
  assign recv_cnt  = recv_cnt_q;
  assign op_finish = op_finish_q;
  assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_datain_buf.sv
// Scoreboard bench for datain_buf: accepted flits are queued as driven and popped on readback.
module tb_datain_buf;
  localparam int DW = 20;
  localparam int D  = 30;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          RST, enable, clear, in_valid;
  logic [DW-1:0] datain;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, checksum;
  logic [AW:0]   recv_cnt;
  logic          op_finish, drop_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] exp_mem [D];
  logic [DW-1:0] exp_ck;

  datain_buf #(.DATA_W(DW), .DEPTH(D), .ADDR_W(AW)) dut (
    .clk(clk), .RST(RST), .enable(enable), .clear(clear), .datain(datain),
    .in_valid(in_valid), .rd_addr(rd_addr), .rd_data(rd_data), .recv_cnt(recv_cnt),
    .op_finish(op_finish), .drop_err(drop_err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: got no end expected end of test");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] ck_exp(input logic [DW-1:0] v);
`ifdef DATAIN_BUF_CHECKSUM_EN
    return v;
`else
    return '0;
`endif
  endfunction

  task automatic step(input logic v, input logic en, input logic clr, input logic [DW-1:0] d);
    @(negedge clk);
    in_valid = v; enable = en; clear = clr; datain = d;
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic do_clear();
    step(1'b0, 1'b1, 1'b1, '0);
    idle();
  endtask

  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    @(negedge clk);
    rd_addr = a; in_valid = 1'b0; clear = 1'b0;
    @(negedge clk);
    chk(tag, rd_data, exp);
  endtask

  // gapmax>0 inserts 1..gapmax idle cycles between beats; beat number bad_idx is sent with enable low
  task automatic send_packet(input int gapmax, input int bad_idx, input logic [DW-1:0] base,
                             input logic exp_drop);
    int k = 0;
    int i = 0;
    exp_ck = '0;
    while (k < D) begin
      if (i == bad_idx) begin
        step(1'b1, 1'b0, 1'b0, 20'h0DEAD);
      end else begin
        step(1'b1, 1'b1, 1'b0, base + DW'(k));
        exp_mem[k] = base + DW'(k);
        exp_ck ^= base + DW'(k);
        rd_q.push_back(base + DW'(k));
        if (k == D-1) begin
          chk("pre_finish", op_finish, 0);
          chk("pre_cnt", recv_cnt, D-1);
        end
        k++;
      end
      i++;
      if (gapmax > 0 && k < D) repeat ($urandom_range(1, gapmax)) idle();
    end
    idle();
    chk("finish", op_finish, 1);
    chk("cnt_full", recv_cnt, D);
    chk("drop_err", drop_err, exp_drop);
    chk("checksum", checksum, ck_exp(exp_ck));
  endtask

  task automatic readback();
    for (int a = 0; a < D; a++) rd_chk("rd", AW'(a), rd_q.pop_front());
  endtask

  initial begin
    RST = 1'b0; enable = 1'b0; clear = 1'b0; in_valid = 1'b0; datain = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    chk("rst_cnt", recv_cnt, 0);
    chk("rst_fin", op_finish, 0);
    chk("rst_drop", drop_err, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_ck", checksum, 0);
    RST = 1'b1;

    // back-to-back packet 0..29
    send_packet(0, -1, '0, 1'b0);
    readback();
    rd_chk("rd_oob", 5'd31, '0);

    // beat after completion is dropped
    step(1'b1, 1'b1, 1'b0, 20'hFFFFF);
    idle();
    chk("done_drop", drop_err, 1);
    chk("done_cnt", recv_cnt, D);
    chk("done_fin", op_finish, 1);
    rd_chk("done_mem0", '0, exp_mem[0]);

    // clear with a simultaneous beat
    step(1'b1, 1'b1, 1'b1, 20'hABCDE);
    idle();
    chk("clr_cnt", recv_cnt, 0);
    chk("clr_fin", op_finish, 0);
    chk("clr_drop", drop_err, 0);
    chk("clr_ck", checksum, 0);
    rd_chk("clr_mem0", '0, exp_mem[0]);
    send_packet(0, -1, 20'h00100, 1'b0);
    readback();

    // gapped packet
    do_clear();
    send_packet(3, -1, '0, 1'b0);
    readback();

    // beat 5 sent with enable low
    do_clear();
    send_packet(0, 5, 20'h00050, 1'b1);
    readback();

    // reset mid-packet, after a drop so drop_err is set
    do_clear();
    step(1'b1, 1'b0, 1'b0, 20'h0BEEF);
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 1'b1, 1'b0, 20'h00200 + DW'(k));
      exp_mem[k] = 20'h00200 + DW'(k);
    end
    idle();
    chk("mid_cnt", recv_cnt, 12);
    chk("mid_drop", drop_err, 1);
    @(negedge clk);
    RST = 1'b0;
    #1;
    chk("arst_cnt", recv_cnt, 0);
    chk("arst_fin", op_finish, 0);
    chk("arst_drop", drop_err, 0);
    chk("arst_rd", rd_data, 0);
    chk("arst_ck", checksum, 0);
    @(negedge clk);
    RST = 1'b1;
    send_packet(0, -1, 20'h00300, 1'b0);
    readback();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/datain_buf.md
Name: datain_buf

Overview:
- Receive-side counterpart of the per-node data injection buffer.
- Captures one 30-flit, 20-bit packet from the NoC ejection port into an internal register-file memory and reports completion.
- Exposes a registered read port so the result checker or host can read captured flits back.
- Sits at each node's ejection port, one instance per receiving node.

Parameters:
- DATA_W, 20, flit width in bits
- DEPTH, 30, flits per packet / memory depth
- ADDR_W, 5, address width; must satisfy 2^ADDR_W >= DEPTH

Ports:
- clk  in  1  single clock, rising edge
- RST  in  1  asynchronous active-low reset
- enable  in  1  receive enable; beats are accepted only while high
- clear  in  1  single-cycle pulse; re-arms the block for a new packet
- datain  in  DATA_W  incoming flit
- in_valid  in  1  datain is valid this cycle
- rd_addr  in  ADDR_W  readback address
- rd_data  out  DATA_W  readback data, registered
- recv_cnt  out  ADDR_W+1  number of flits stored, 0..DEPTH
- op_finish  out  1  packet complete (DEPTH flits stored)
- drop_err  out  1  sticky: a beat was dropped (enable low, or arrived after completion)
- checksum  out  DATA_W  running XOR of stored flits (see Optional Feature)

Behaviour:
- Reset (RST low, async): state=IDLE, wr_addr=0, recv_cnt=0, op_finish=0, drop_err=0, rd_data=0, checksum=0. Memory contents are not reset (undefined until written).
- Accepted beat: in_valid & enable & state!=DONE & !clear.
- FSM states: IDLE, RECV, DONE.
- IDLE:
  - Accepted beat: mem[0]<=datain, wr_addr<=1, recv_cnt<=1, go to RECV.
  - in_valid & !enable: drop_err<=1, stay in IDLE.
- RECV:
  - Accepted beat: mem[wr_addr]<=datain, recv_cnt+1.
  - If wr_addr==DEPTH-1: wr_addr<=0, op_finish<=1, go to DONE. Otherwise wr_addr+1.
  - in_valid & !enable: beat dropped, drop_err<=1, state and address held.
  - Gaps (in_valid low) are allowed anywhere; no timeout.
- DONE:
  - All in_valid beats are dropped, drop_err<=1, no memory write, recv_cnt held at DEPTH.
  - op_finish stays high until clear or reset.
- clear (any state): next cycle state=IDLE, wr_addr=0, recv_cnt=0, op_finish=0, drop_err=0, checksum=0. Memory is not cleared.
- clear wins over a simultaneous beat. That beat is discarded and does not set drop_err.
- Latencies:
  - Write takes effect at the accepting edge.
  - recv_cnt and op_finish update at the same edge as the final write. op_finish is high the cycle after the 30th beat.
  - Read: rd_data<=mem[rd_addr] every cycle, 1-cycle latency.
  - Same-cycle read and write to the same address returns the old data (read-first).
  - rd_addr>=DEPTH returns 0.
- recv_cnt never exceeds DEPTH; wr_addr never exceeds DEPTH-1.
- Reset asserted mid-packet aborts immediately to the reset state. A packet partially captured before reset is not resumed.

Optional Feature:
- Macro DATAIN_BUF_CHECKSUM_EN.
- Defined: checksum<=checksum ^ datain on every accepted beat, cleared by reset and by clear. After DONE it equals the XOR of all DEPTH stored flits.
- Not defined: checksum is tied to 0, and no checksum register is synthesized.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then 30 back-to-back beats datain=0x00000..0x0001D with enable=1 -> op_finish rises the cycle after beat 30; recv_cnt=30; reading rd_addr k gives k one cycle later; drop_err=0; checksum=0x00001 with macro defined (XOR of 0..29), 0 otherwise.
- Same 30 beats with in_valid gaps of 1-3 idle cycles -> identical memory contents and recv_cnt=30; op_finish only after the 30th valid beat.
- Beat 5 presented with enable=0 -> that flit is not stored; drop_err=1; packet completes only after 30 accepted beats; recv_cnt=30.
- After DONE, drive in_valid with datain=0xFFFFF -> mem[0] unchanged; drop_err=1; recv_cnt stays 30.
- Pulse clear together with in_valid datain=0xABCDE in DONE -> next cycle state IDLE, recv_cnt=0, op_finish=0, drop_err=0; 0xABCDE is not written; next packet overwrites from address 0.
- Assert RST low after 12 beats, then release -> all outputs return to reset values; a new 30-beat packet completes normally with recv_cnt=30.
